// File: rtl/uart_link_monitor_if.sv
// Line and status bundle between the SoC-side harness and the UART link monitor.
// Latency: none, wires only.
// Backpressure: none; frame_valid is a one-cycle strobe with no ready.
interface uart_link_monitor_if #(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 16
);
    logic                 tx_in;
    logic                 rx_out;
    logic [1:0]           mode;
    logic                 inject;
    logic                 frame_valid;
    logic [DATA_BITS-1:0] frame_data;
    logic                 frame_err;
    logic                 break_det;
    logic [CNT_W-1:0]     frame_cnt;
    logic [CNT_W-1:0]     err_cnt;

    // Harness side: drives the SoC transmit line and the line controls.
    modport master (
        output tx_in, mode, inject,
        input  rx_out, frame_valid, frame_data, frame_err, break_det, frame_cnt, err_cnt
    );

    // Monitor side.
    modport slave (
        input  tx_in, mode, inject,
        output rx_out, frame_valid, frame_data, frame_err, break_det, frame_cnt, err_cnt
    );
endinterface

// File: rtl/uart_link_monitor.sv
// UART line monitor: decodes SoC tx frames, counts good/bad frames, detects break, drives return line.
// Latency: rx_out 1 cycle after tx_in/mode; frame_valid 1 cycle after the stop-bit sample.
// Backpressure: none; the monitor is passive and every strobe is single-cycle.
module uart_link_monitor #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int BREAK_BITS = 12,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_link_monitor_if.slave line
);

    localparam int CW  = $clog2(CLK_DIV);
    localparam int IW  = $clog2(DATA_BITS);
    localparam int THR = BREAK_BITS * CLK_DIV;
    localparam int LW  = $clog2(THR + 1);

    localparam logic [CW-1:0] HALF     = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [LW-1:0] THR_L    = LW'(THR);
    localparam logic [LW-1:0] THR_M1   = LW'(THR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]        bit_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 armed;
    logic                 rx_q;
    logic                 valid_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 err_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic [CNT_W-1:0]     err_cnt_q;
    logic [LW-1:0]        low_cnt;
    logic [CW-1:0]        high_cnt;
    logic                 break_q;

    logic sample, bit_end, last_idx, flip, stop_sample, par_err, frame_bad, clear_armed;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state: walk start, data, optional parity and stop bits; stop low parks in WAIT_HIGH.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (!line.tx_in) state_nxt = S_START;
            S_START:     if (sample && line.tx_in) state_nxt = S_IDLE;
                         else if (bit_end)         state_nxt = S_DATA;
            S_DATA:      if (bit_end && last_idx)
                             state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (bit_end) state_nxt = S_STOP;
            S_STOP:      if (sample) state_nxt = line.tx_in ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (line.tx_in) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Per-state decode: sample/bit-end strobes, injection window and frame error.
    always_comb begin
        sample      = (bit_cnt == HALF);
        bit_end     = (bit_cnt == LAST);
        last_idx    = (bit_idx == LAST_IDX);
        flip        = armed && (state == S_DATA) && (bit_idx == '0);
        clear_armed = flip && bit_end && (line.mode == 2'd3);
        stop_sample = (state == S_STOP) && sample;
        par_err     = (PARITY != 0) && (((^shift) ^ par_bit) != (PARITY == 2));
        frame_bad   = !line.tx_in || par_err;
    end

    // Bit timing and data capture; the counter is 0 on the start-detect cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (state == S_IDLE) bit_cnt <= line.tx_in ? '0 : CW'(1);
            else                 bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);

            if (state != S_DATA) bit_idx <= '0;
            else if (bit_end)    bit_idx <= bit_idx + IW'(1);

            // LSB arrives first, so shift in from the top.
            if (state == S_DATA && sample) shift <= {line.tx_in, shift[DATA_BITS-1:1]};
            if (state == S_PARITY && sample) par_bit <= line.tx_in;
        end
    end

    // Frame result registers and saturating counters, updated at the stop sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            valid_q <= stop_sample;
            if (stop_sample) begin
                data_q <= shift;
                err_q  <= frame_bad;
                if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                if (frame_bad && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    // Injection arm flag: a new inject pulse beats the end-of-bit-0 clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              armed <= 1'b0;
        else if (line.inject) armed <= 1'b1;
        else if (clear_armed) armed <= 1'b0;
    end

    // Return line, registered from tx_in and mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_q <= 1'b1;
        else begin
            case (line.mode)
                2'd0:    rx_q <= line.tx_in;
                2'd1:    rx_q <= 1'b1;
                2'd2:    rx_q <= 1'b0;
                default: rx_q <= line.tx_in ^ flip;
            endcase
        end
    end

    // Break detector: long low run sets, one bit period of high clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_cnt  <= '0;
            high_cnt <= '0;
            break_q  <= 1'b0;
        end else if (!line.tx_in) begin
            high_cnt <= '0;
            if (low_cnt != THR_L) low_cnt <= low_cnt + LW'(1);
            if (low_cnt >= THR_M1) break_q <= 1'b1;
        end else begin
            low_cnt <= '0;
            if (high_cnt != LAST) high_cnt <= high_cnt + CW'(1);
            if (high_cnt == LAST) break_q <= 1'b0;
        end
    end

    assign line.rx_out      = rx_q;
    assign line.frame_valid = valid_q;
    assign line.frame_data  = data_q;
    assign line.frame_err   = err_q;
    assign line.break_det   = break_q;
    assign line.frame_cnt   = frame_cnt_q;
    assign line.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_link_monitor.sv
// Bench for uart_link_monitor: randomized frames, scoreboard of expected frames, per-cycle line model.
// Latency: expects frame_valid (1+DATA_BITS+P)*CLK_DIV + CLK_DIV/2 + 1 cycles after the start bit.
// Backpressure: none.
module tb_uart_link_monitor;

    localparam int CLK_DIV    = 16;
    localparam int DATA_BITS  = 8;
    localparam int PARITY     = 1;
    localparam int BREAK_BITS = 12;
    localparam int CNT_W      = 16;
    localparam int P          = (PARITY != 0) ? 1 : 0;
    localparam int VALID_LAT  = (1 + DATA_BITS + P) * CLK_DIV + CLK_DIV / 2 + 1;
    localparam int BRK_LAT    = BREAK_BITS * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_link_monitor_if #(.DATA_BITS(DATA_BITS), .CNT_W(CNT_W)) line ();

    uart_link_monitor #(
        .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY(PARITY),
        .BREAK_BITS(BREAK_BITS), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .line (line)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 err;
        int                   at;
    } exp_t;

    exp_t sb[$];
    int   exp_frames = 0;
    int   exp_errs   = 0;
    bit   armed_m    = 1'b0;
    int   flip_lo    = -100;
    int   flip_hi    = -100;

    // Line model state, captured at each rising edge.
    int         lo_run    = 0;
    int         hi_run    = 0;
    bit         brk_m     = 1'b0;
    logic       prev_tx   = 1'b1;
    logic [1:0] prev_mode = 2'd0;
    int         prev_cyc  = -1;
    bit         prev_rst  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural line model: run lengths of low/high on tx_in, and the previous cycle's inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_run   = 0;
            hi_run   = 0;
            brk_m    = 1'b0;
            prev_rst = 1'b1;
        end else begin
            if (!line.tx_in) begin
                lo_run++;
                hi_run = 0;
                if (lo_run >= BRK_LAT) brk_m = 1'b1;
            end else begin
                hi_run++;
                lo_run = 0;
                if (hi_run >= CLK_DIV) brk_m = 1'b0;
            end
            prev_tx   = line.tx_in;
            prev_mode = line.mode;
            prev_cyc  = cyc;
            prev_rst  = 1'b0;
        end
    end

    // Monitor: compare the return line every cycle and pop the scoreboard on each frame_valid.
    always @(negedge clk) begin
        logic exp_rx;
        exp_t e;
        if (rst || prev_rst) exp_rx = 1'b1;
        else begin
            case (prev_mode)
                2'd0:    exp_rx = prev_tx;
                2'd1:    exp_rx = 1'b1;
                2'd2:    exp_rx = 1'b0;
                default: exp_rx = prev_tx ^ ((prev_cyc >= flip_lo) && (prev_cyc <= flip_hi));
            endcase
        end
        check("rx_out", {31'd0, line.rx_out}, {31'd0, exp_rx});
        check("break_det", {31'd0, line.break_det}, {31'd0, brk_m});
        if (line.frame_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_valid", {31'd0, line.frame_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                if (exp_frames < (1 << CNT_W) - 1) exp_frames++;
                if (e.err && exp_errs < (1 << CNT_W) - 1) exp_errs++;
                check("frame_time", cyc, e.at);
                check("frame_data", {24'd0, line.frame_data}, {24'd0, e.data});
                check("frame_err", {31'd0, line.frame_err}, {31'd0, e.err});
                check("frame_cnt", {16'd0, line.frame_cnt}, exp_frames);
                check("err_cnt", {16'd0, line.err_cnt}, exp_errs);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic b, input int n);
        line.tx_in = b;
        tick(n);
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit bad_par, input bit stop);
        exp_t e;
        logic p;
        p      = (^d) ^ bad_par;
        e.data = d;
        e.err  = bad_par || !stop;
        e.at   = cyc + VALID_LAT;
        sb.push_back(e);
        if (line.mode == 2'd3 && armed_m) begin
            flip_lo = cyc + CLK_DIV;
            flip_hi = cyc + 2 * CLK_DIV - 1;
            armed_m = 1'b0;
        end
        send_bits(1'b0, CLK_DIV);
        for (int i = 0; i < DATA_BITS; i++) send_bits(d[i], CLK_DIV);
        send_bits(p, CLK_DIV);
        send_bits(stop, CLK_DIV);
        line.tx_in = 1'b1;
    endtask

    task automatic pulse_inject();
        line.inject = 1'b1;
        tick(1);
        line.inject = 1'b0;
        armed_m     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_out"}, {31'd0, line.rx_out}, 32'd1);
        check({tag, "_frame_valid"}, {31'd0, line.frame_valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, line.frame_err}, 32'd0);
        check({tag, "_break_det"}, {31'd0, line.break_det}, 32'd0);
        check({tag, "_frame_data"}, {24'd0, line.frame_data}, 32'd0);
        check({tag, "_frame_cnt"}, {16'd0, line.frame_cnt}, 32'd0);
        check({tag, "_err_cnt"}, {16'd0, line.err_cnt}, 32'd0);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        line.tx_in  = 1'b1;
        line.mode   = 2'd0;
        line.inject = 1'b0;
        rst         = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        // Plain loopback, good frame with even parity.
        send_frame(8'hA5, 1'b0, 1'b1);
        tick(5);

        // Injection on the next frame only.
        line.mode = 2'd3;
        tick(2);
        pulse_inject();
        tick(3);
        send_frame(8'h3C, 1'b0, 1'b1);
        tick(3);
        send_frame(8'h5A, 1'b0, 1'b1);
        tick(3);
        line.mode = 2'd0;
        tick(2);

        // 0x01 carried with parity bit 0: parity error.
        send_frame(8'h01, 1'b1, 1'b1);
        tick(5);

        // Long low: one errored frame, then break, then release.
        begin
            exp_t e;
            e.data = '0;
            e.err  = 1'b1;
            e.at   = cyc + VALID_LAT;
            sb.push_back(e);
        end
        n = cyc;
        line.tx_in = 1'b0;
        tick(BRK_LAT - 1);
        check("break_before_threshold", {31'd0, line.break_det}, 32'd0);
        tick(1);
        check("break_rise", {31'd0, line.break_det}, 32'd1);
        check("break_rise_cycle", cyc, n + BRK_LAT);
        tick(300 - BRK_LAT);
        line.tx_in = 1'b1;
        tick(CLK_DIV - 1);
        check("break_hold_high15", {31'd0, line.break_det}, 32'd1);
        tick(1);
        check("break_fall", {31'd0, line.break_det}, 32'd0);
        tick(200);
        check("after_break_frame_cnt", {16'd0, line.frame_cnt}, exp_frames);
        check("after_break_err_cnt", {16'd0, line.err_cnt}, exp_errs);

        // Short low glitch.
        send_bits(1'b0, 4);
        send_bits(1'b1, 24);
        check("glitch_frame_cnt", {16'd0, line.frame_cnt}, exp_frames);
        check("glitch_err_cnt", {16'd0, line.err_cnt}, exp_errs);

        // Randomized traffic across all line modes.
        for (int k = 0; k < 40; k++) begin
            line.mode = 2'($urandom_range(0, 3));
            tick(1);
            if (line.mode == 2'd3 && $urandom_range(0, 1) == 1) begin
                pulse_inject();
                tick(1);
            end
            r = $urandom_range(0, 5);
            if (r == 0) begin
                send_bits(1'b0, $urandom_range(1, 7));
                send_bits(1'b1, 20);
                check("rand_glitch_frame_cnt", {16'd0, line.frame_cnt}, exp_frames);
            end else begin
                send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0);
            end
            tick($urandom_range(1, 20));
        end
        line.mode = 2'd0;
        tick(5);

        // Reset in the middle of a frame.
        send_bits(1'b0, CLK_DIV);
        send_bits(1'b1, 30);
        rst = 1'b1;
        #2;
        check_reset_outputs("midframe_reset");
        exp_frames = 0;
        exp_errs   = 0;
        armed_m    = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(250);
        check("post_reset_frame_cnt", {16'd0, line.frame_cnt}, 32'd0);
        check("post_reset_rx_out", {31'd0, line.rx_out}, 32'd1);

        tick(5);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
